// File: rtl/axilite_arbiter.sv
// Two-requester round-robin front end onto a single AXI4-Lite master port.
// One transaction is in flight at a time; its completion is reported to the requester that issued it.
module axilite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  // requester 0
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_wstrb,
  output logic                req0_ready,
  output logic                req0_done,
  output logic [DATA_W-1:0]   req0_rdata,
  output logic [1:0]          req0_resp,
  // requester 1
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_wstrb,
  output logic                req1_ready,
  output logic                req1_done,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic [1:0]          req1_resp,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP} state_t;

  state_t              state;
  logic                grant;
  logic                grant_id;
  logic                owner;
  logic                last_id;
  logic                aw_ok;
  logic                w_ok;
  logic [1:0]          done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q [2];
  logic [1:0]          resp_q  [2];

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == IDLE) begin
      grant = req0_valid | req1_valid;
      // on a tie, the requester not served last goes first
      if (req0_valid && req1_valid) grant_id = ~last_id;
      else                          grant_id = req1_valid;
    end
  end

  assign req0_ready = grant & ~grant_id;
  assign req1_ready = grant & grant_id;

  // a write channel is finished once its valid has dropped or is handshaking now
  assign aw_ok = ~awvalid | awready;
  assign w_ok  = ~wvalid  | wready;

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_rdata = rdata_q[0];
  assign req1_rdata = rdata_q[1];
  assign req0_resp  = resp_q[0];
  assign req1_resp  = resp_q[1];

  // NOTE: the payload holding registers carry no reset; they are only observed while a valid qualifies them.
  always_ff @(posedge aclk) begin
    if (grant) begin
      addr_q  <= grant_id ? req1_addr  : req0_addr;
      wdata_q <= grant_id ? req1_wdata : req0_wdata;
      wstrb_q <= grant_id ? req1_wstrb : req0_wstrb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; done_q is cleared by default and a later assignment in the same pass overrides it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      bready  <= 1'b0;
      rready  <= 1'b0;
      busy    <= 1'b0;
      done_q  <= '0;
      owner   <= 1'b0;
      last_id <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        rdata_q[i] <= '0;
        resp_q[i]  <= '0;
      end
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner   <= grant_id;
            last_id <= grant_id;
            busy    <= 1'b1;
            if (grant_id ? req1_we : req0_we) begin
              state   <= WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RD;
              arvalid <= 1'b1;
            end
          end
        end
        WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            state  <= WRESP;
            bready <= 1'b1;
          end
        end
        WRESP: begin
          // the done cycle is spent here so no new grant can overlap it
          if (done_q != '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bvalid && bready) begin
            bready         <= 1'b0;
            done_q[owner]  <= 1'b1;
            resp_q[owner]  <= bresp;
          end
        end
        RD: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RRESP;
          end
        end
        RRESP: begin
          if (done_q != '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rvalid && rready) begin
            rready         <= 1'b0;
            done_q[owner]  <= 1'b1;
            rdata_q[owner] <= rdata;
            resp_q[owner]  <= rresp;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_arbiter.sv
// Directed bench for axilite_arbiter: stimulus pushes expected transactions into a
// scoreboard; a negedge monitor/slave model checks AXI payloads and completions against it.
module tb_axilite_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [3:0]  req0_wstrb = '0;
  logic        req0_ready, req0_done;
  logic [31:0] req0_rdata;
  logic [1:0]  req0_resp;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req1_wstrb = '0;
  logic        req1_ready, req1_done;
  logic [31:0] req1_rdata;
  logic [1:0]  req1_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready, busy;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  axilite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_wstrb(req0_wstrb), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_wstrb(req1_wstrb), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } txn_t;

  txn_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [31:0] model_rdata [2] = '{32'h0, 32'h0};
  logic [1:0]  model_resp  [2] = '{2'b00, 2'b00};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit id, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] strb,
                               input logic [31:0] rd, input logic [1:0] resp, input int lat);
    txn_t t;
    t.id = id; t.we = we; t.addr = addr; t.wdata = wd; t.wstrb = strb;
    t.rdata = rd; t.resp = resp; t.lat = lat;
    sb.push_back(t);
  endfunction

  // ---------------- monitor + slave model (all on negedge) ----------------
  int   cyc = 0, ready_cyc = 0, resp_phases = 0;
  int   aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit   aw_seen = 0, w_seen = 0, ar_seen = 0;
  bit   aw_hs = 0, w_hs = 0, ar_hs = 0, b_fire = 0, r_fire = 0;
  logic bready_q = 1'b0, rready_q = 1'b0;
  txn_t e;

  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_fire = 0; r_fire = 0;
      resp_phases = 0; bready_q = 0; rready_q = 0;
    end else begin
      // consequences of the handshakes committed at the posedge just gone
      if (aw_hs) check("awvalid_drop", awvalid, 0);
      if (w_hs)  check("wvalid_drop", wvalid, 0);
      if (ar_hs) check("arvalid_drop", arvalid, 0);
      if (b_fire) begin check("bready_drop", bready, 0); bvalid = 0; aw_seen = 0; w_seen = 0; end
      if (r_fire) begin check("rready_drop", rready, 0); rvalid = 0; ar_seen = 0; end
      if (aw_wait > 0) check("awvalid_held", awvalid, 1);
      if (w_wait > 0)  check("wvalid_held", wvalid, 1);
      if (ar_wait > 0) check("arvalid_held", arvalid, 1);
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_fire = 0; r_fire = 0;

      if (arvalid) check("ar_aw_exclusive", awvalid | wvalid, 0);
      if (req0_ready) check("single_ready", req1_ready, 0);
      if (req0_ready || req1_ready) begin
        ready_cyc = cyc;
        check("busy_in_idle", busy, 0);
        check("grant_queue_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check("grant_id", req1_ready, sb[0].id);
      end
      if (bready && !bready_q) resp_phases++;
      if (rready && !rready_q) resp_phases++;
      bready_q = bready;
      rready_q = rready;

      if (req0_done || req1_done) begin
        check("single_done", req0_done & req1_done, 0);
        check("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_id", req1_done, e.id);
          check("busy_at_done", busy, 1);
          check("resp_phases", resp_phases, 1);
          if (e.lat >= 0) check("latency", cyc - ready_cyc, e.lat);
          if (!e.we) model_rdata[e.id] = e.rdata;
          model_resp[e.id] = e.resp;
          check("resp", e.id ? req1_resp : req0_resp, e.resp);
          check("rdata0", req0_rdata, model_rdata[0]);
          check("rdata1", req1_rdata, model_rdata[1]);
        end
        resp_phases = 0;
      end

      // slave responses, from handshakes completed at earlier edges
      if (aw_seen && w_seen && !bvalid) begin
        if (b_wait >= b_delay) begin
          bvalid = 1; b_wait = 0;
          bresp = (sb.size() != 0) ? sb[0].resp : 2'b00;
        end else b_wait++;
      end
      if (ar_seen && !rvalid) begin
        if (r_wait >= r_delay) begin
          rvalid = 1; r_wait = 0;
          rdata = (sb.size() != 0) ? sb[0].rdata : 32'h0;
          rresp = (sb.size() != 0) ? sb[0].resp : 2'b00;
        end else r_wait++;
      end
      if (bvalid && bready) b_fire = 1;
      if (rvalid && rready) r_fire = 1;

      // address/data channel readies
      awready = 0;
      if (awvalid && !aw_seen) begin
        if (aw_wait >= aw_delay) begin
          awready = 1; aw_seen = 1; aw_hs = 1; aw_wait = 0;
          if (sb.size() != 0) check("awaddr", awaddr, sb[0].addr);
        end else aw_wait++;
      end
      wready = 0;
      if (wvalid && !w_seen) begin
        if (w_wait >= w_delay) begin
          wready = 1; w_seen = 1; w_hs = 1; w_wait = 0;
          if (sb.size() != 0) begin
            check("wdata", wdata, sb[0].wdata);
            check("wstrb", wstrb, sb[0].wstrb);
          end
        end else w_wait++;
      end
      arready = 0;
      if (arvalid && !ar_seen) begin
        if (ar_wait >= ar_delay) begin
          arready = 1; ar_seen = 1; ar_hs = 1; ar_wait = 0;
          if (sb.size() != 0) check("araddr", araddr, sb[0].addr);
        end else ar_wait++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input bit id, input logic v, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb);
    if (id) begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wd; req1_wstrb = strb;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wd; req0_wstrb = strb;
    end
  endtask

  // called just after a posedge; returns just after the posedge that accepted the request
  task automatic drive(input bit id, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    bit ok;
    ok = 1'b0;
    set_req(id, 1'b1, we, addr, wd, strb);
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    set_req(id, 1'b0, we, addr, wd, strb);
    check("accept_in_time", ok, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset(input string name);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    sb.delete();
    model_rdata[0] = '0; model_rdata[1] = '0;
    model_resp[0]  = '0; model_resp[1]  = '0;
    @(posedge aclk);
    @(negedge aclk);
    check({name, "_awvalid"}, awvalid, 0);
    check({name, "_wvalid"}, wvalid, 0);
    check({name, "_arvalid"}, arvalid, 0);
    check({name, "_bready"}, bready, 0);
    check({name, "_rready"}, rready, 0);
    check({name, "_ready0"}, req0_ready, 0);
    check({name, "_ready1"}, req1_ready, 0);
    check({name, "_done0"}, req0_done, 0);
    check({name, "_done1"}, req1_done, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_rdata0"}, req0_rdata, model_rdata[0]);
    check({name, "_rdata1"}, req1_rdata, model_rdata[1]);
    check({name, "_resp0"}, req0_resp, model_resp[0]);
    check({name, "_resp1"}, req1_resp, model_resp[1]);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    bit got_rready;
    apply_reset("por");

    // single write from req0, prompt slave
    push(0, 1, 32'h0, 32'h11223344, 4'b1111, 32'h0, 2'b00, 3);
    drive(0, 1, 32'h0, 32'h11223344, 4'b1111);
    drain("wr0");

    // single read from req1; req0_rdata must stay put
    push(1, 0, 32'h4, 32'h0, 4'b0000, 32'h55667788, 2'b00, 3);
    drive(1, 0, 32'h4, 32'h0, 4'b0000);
    drain("rd1");

    // req0 read leaves the pointer on req0 before reset
    push(0, 0, 32'h10, 32'h0, 4'b0000, 32'hA5A50001, 2'b01, 3);
    drive(0, 0, 32'h10, 32'h0, 4'b0000);
    drain("rd0");

    // reset clears read data and re-arms the pointer for req0
    apply_reset("rst_pointer");

    // both requesters held for two transactions each: 0,1,0,1
    push(0, 1, 32'h20, 32'hDEAD0001, 4'b0011, 32'h0, 2'b00, 3);
    push(1, 0, 32'h24, 32'h0, 4'b0000, 32'h0BAD0002, 2'b00, 3);
    push(0, 0, 32'h28, 32'h0, 4'b0000, 32'h12345678, 2'b01, 3);
    push(1, 1, 32'h2C, 32'hFEEDBEEF, 4'b1000, 32'h0, 2'b00, 3);
    fork
      begin
        drive(0, 1, 32'h20, 32'hDEAD0001, 4'b0011);
        drive(0, 0, 32'h28, 32'h0, 4'b0000);
      end
      begin
        drive(1, 0, 32'h24, 32'h0, 4'b0000);
        drive(1, 1, 32'h2C, 32'hFEEDBEEF, 4'b1000);
      end
    join
    drain("tie");

    // write data accepted three cycles before the address
    aw_delay = 3; w_delay = 0;
    push(0, 1, 32'h100, 32'hAABBCCDD, 4'b1111, 32'h0, 2'b00, 6);
    drive(0, 1, 32'h100, 32'hAABBCCDD, 4'b1111);
    drain("w_first");

    // both write channels handshake in the same cycle after a wait
    aw_delay = 2; w_delay = 2;
    push(0, 1, 32'h104, 32'h01020304, 4'b0110, 32'h0, 2'b00, 5);
    drive(0, 1, 32'h104, 32'h01020304, 4'b0110);
    drain("aw_w_same");
    aw_delay = 0; w_delay = 0;

    // SLVERR on a req1 write, then a normal req1 read
    push(1, 1, 32'h30, 32'h0F0F0F0F, 4'b0101, 32'h0, 2'b10, 3);
    drive(1, 1, 32'h30, 32'h0F0F0F0F, 4'b0101);
    push(1, 0, 32'h34, 32'h0, 4'b0000, 32'h77778888, 2'b00, 3);
    drive(1, 0, 32'h34, 32'h0, 4'b0000);
    drain("slverr");

    // reset while waiting in RRESP abandons the read without a done
    r_delay = 6;
    push(0, 0, 32'h40, 32'h0, 4'b0000, 32'h99990000, 2'b00, -1);
    drive(0, 0, 32'h40, 32'h0, 4'b0000);
    got_rready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rready === 1'b1) begin
        got_rready = 1'b1;
        break;
      end
    end
    check("reach_rresp", got_rready, 1);
    apply_reset("rst_rresp");
    r_delay = 0;
    repeat (6) @(negedge aclk);
    @(posedge aclk);
    #1;
    push(0, 0, 32'h8, 32'h0, 4'b0000, 32'hCAFEF00D, 2'b00, 3);
    drive(0, 0, 32'h8, 32'h0, 4'b0000);
    drain("after_rst");

    repeat (3) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
